// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with true-LRU replacement and a
// sequential one-set-per-cycle flush engine that runs out of reset and on request.
module btb_assoc #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 10,
  localparam int IDX_W = $clog2(SETS),
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lookup_pc,
  output logic             hit,
  output logic [AGE_W-1:0] hit_way,
  output logic [31:0]      bta,
  output logic [1:0]       br_type,
  input  logic             update_en,
  input  logic             update_inval,
  input  logic [31:0]      update_pc,
  input  logic [31:0]      update_bta,
  input  logic [1:0]       update_type,
  input  logic             flush_req,
  output logic             flush_busy
);

  localparam int RAW_W  = 30 - IDX_W;
  localparam int CHUNKS = (RAW_W + TAG_W - 1) / TAG_W;

  typedef logic [TAG_W-1:0]                tag_t;
  typedef logic [AGE_W-1:0]                age_t;
  typedef logic [WAYS-1:0][AGE_W-1:0]      age_vec_t;
  typedef enum logic {IDLE, FLUSH}         state_t;

  // Upper PC bits are zero-extended to whole chunks and XOR-folded into TAG_W bits.
  function automatic tag_t fold_tag(input logic [31:0] pc);
    logic [CHUNKS*TAG_W-1:0] ext;
    tag_t                    acc;
    ext            = '0;
    ext[RAW_W-1:0] = pc[31:IDX_W+2];
    acc            = '0;
    for (int c = 0; c < CHUNKS; c++) acc ^= ext[c*TAG_W +: TAG_W];
    return acc;
  endfunction

  function automatic age_vec_t touch(input age_vec_t ages, input age_t way);
    age_vec_t nxt;
    nxt = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (age_t'(w) == way)          nxt[w] = '0;
      else if (ages[w] < ages[way])  nxt[w] = ages[w] + 1'b1;
    end
    return nxt;
  endfunction

  function automatic age_vec_t fresh_ages();
    age_vec_t v;
    for (int w = 0; w < WAYS; w++) v[w] = age_t'(w);
    return v;
  endfunction

  state_t           state;
  logic [IDX_W-1:0] fidx;

  // NOTE: the entry arrays are deliberately not reset; the flush engine that
  // runs out of reset clears valid bits and ages, and nothing reads them before.
  logic [WAYS-1:0]  valid_q [SETS];
  tag_t             tag_q   [SETS][WAYS];
  logic [31:0]      bta_q   [SETS][WAYS];
  logic [1:0]       type_q  [SETS][WAYS];
  age_vec_t         age_q   [SETS];

  logic [IDX_W-1:0] l_idx, u_idx;
  tag_t             l_tag, u_tag;
  logic [WAYS-1:0]  l_match, u_match;
  logic             l_any, u_any, free_any;
  age_t             l_way, u_way, free_way, lru_way, wr_way;
  logic             upd_go, upd_wr, upd_clr, lk_touch;

  assign flush_busy = (state == FLUSH);

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign l_tag = fold_tag(lookup_pc);
  assign u_tag = fold_tag(update_pc);

  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a value held and infer a latch.
  always_comb begin
    l_match  = '0;
    u_match  = '0;
    l_any    = 1'b0;
    u_any    = 1'b0;
    free_any = 1'b0;
    l_way    = '0;
    u_way    = '0;
    free_way = '0;
    lru_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      l_match[w] = valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag);
      u_match[w] = valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag);
    end
    // Descending scans leave the lowest-numbered qualifying way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (l_match[w]) begin
        l_any = 1'b1;
        l_way = age_t'(w);
      end
      if (u_match[w]) begin
        u_any = 1'b1;
        u_way = age_t'(w);
      end
      if (!valid_q[u_idx][w]) begin
        free_any = 1'b1;
        free_way = age_t'(w);
      end
      if (WAYS > 1 && age_q[u_idx][w] == age_t'(WAYS - 1)) lru_way = age_t'(w);
    end
  end

  assign wr_way   = u_any ? u_way : (free_any ? free_way : lru_way);
  assign upd_go   = update_en && !flush_busy;
  assign upd_wr   = upd_go && !update_inval;
  assign upd_clr  = upd_go && update_inval && u_any;
  // An update to the same set owns that set's ages this cycle.
  assign lk_touch = hit && !(upd_go && (u_idx == l_idx));

  always_comb begin
    hit     = l_any && !flush_busy;
    hit_way = '0;
    bta     = lookup_pc;
    br_type = 2'b00;
    if (hit) begin
      hit_way = l_way;
      bta     = bta_q[l_idx][l_way];
      br_type = type_q[l_idx][l_way];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FLUSH;
      fidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= FLUSH;
            fidx  <= '0;
          end
        end
        FLUSH: begin
          fidx <= fidx + 1'b1;
          if (fidx == IDX_W'(SETS - 1)) state <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush_busy) begin
      valid_q[fidx] <= '0;
      age_q[fidx]   <= fresh_ages();
    end else begin
      if (upd_wr) begin
        valid_q[u_idx][wr_way] <= 1'b1;
        tag_q[u_idx][wr_way]   <= u_tag;
        bta_q[u_idx][wr_way]   <= update_bta;
        type_q[u_idx][wr_way]  <= update_type;
        age_q[u_idx]           <= touch(age_q[u_idx], wr_way);
      end else if (upd_clr) begin
        valid_q[u_idx][u_way]  <= 1'b0;
      end
      if (lk_touch) age_q[l_idx] <= touch(age_q[l_idx], l_way);
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: a queue-based LRU model checked every cycle,
// plus hand-computed expectations on the key scenarios.
module tb_btb_assoc;

  localparam int SETS  = 64;
  localparam int WAYS  = 2;
  localparam int TAG_W = 10;
  localparam int IDX_W = 6;
  localparam logic [31:0] PARK = 32'h0000_00F0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lookup_pc = 32'h400;
  logic        hit;
  logic [0:0]  hit_way;
  logic [31:0] bta;
  logic [1:0]  br_type;
  logic        update_en = 1'b0;
  logic        update_inval = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_bta = '0;
  logic [1:0]  update_type = '0;
  logic        flush_req = 1'b0;
  logic        flush_busy;

  btb_assoc #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .hit(hit), .hit_way(hit_way),
    .bta(bta), .br_type(br_type), .update_en(update_en), .update_inval(update_inval),
    .update_pc(update_pc), .update_bta(update_bta), .update_type(update_type),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: entries per set plus an MRU-first list of way numbers.
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_bta   [SETS][WAYS];
  logic [1:0]  m_type  [SETS][WAYS];
  int          m_order [SETS][$];
  int          m_left = SETS;

  function automatic int unsigned tag_of(input logic [31:0] pc);
    int unsigned raw, t;
    raw = pc >> (IDX_W + 2);
    t = 0;
    while (raw != 0) begin
      t ^= raw % (1 << TAG_W);
      raw = raw >> TAG_W;
    end
    return t;
  endfunction

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int find(input logic [31:0] pc);
    int s;
    s = set_of(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int i = 0; i < m_order[s].size(); i++)
      if (m_order[s][i] == w) begin
        m_order[s].delete(i);
        break;
      end
    m_order[s].push_front(w);
  endtask

  always @(posedge clk or posedge reset) begin : model_step
    int s, ls, lw, us, uw;
    if (reset) begin
      m_left = SETS;
    end else if (m_left > 0) begin
      s = SETS - m_left;
      m_order[s] = {};
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_order[s].push_back(w);
      end
      m_left--;
    end else begin
      ls = set_of(lookup_pc);
      lw = find(lookup_pc);
      us = set_of(update_pc);
      uw = find(update_pc);
      if (update_en) begin
        if (update_inval) begin
          if (uw >= 0) m_valid[us][uw] = 1'b0;
        end else begin
          if (uw < 0)
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[us][w]) uw = w;
          if (uw < 0) uw = m_order[us][$];
          m_valid[us][uw] = 1'b1;
          m_tag[us][uw]   = tag_of(update_pc);
          m_bta[us][uw]   = update_bta;
          m_type[us][uw]  = update_type;
          m_touch(us, uw);
        end
      end
      if (lw >= 0 && !(update_en && us == ls)) m_touch(ls, lw);
      if (flush_req) m_left = SETS;
    end
  end

  always @(negedge clk) begin : compare
    int w, s;
    if ($time > 2) begin
      s = set_of(lookup_pc);
      w = (m_left > 0) ? -1 : find(lookup_pc);
      check("flush_busy", 32'(flush_busy), 32'(m_left > 0));
      check("hit",        32'(hit),        32'(w >= 0));
      check("hit_way",    32'(hit_way),    (w >= 0) ? 32'(w) : 32'd0);
      check("bta",        bta,             (w >= 0) ? m_bta[s][w] : lookup_pc);
      check("type",       32'(br_type),    (w >= 0) ? 32'(m_type[s][w]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [1:0] t, input logic inval);
    lookup_pc    = PARK;
    update_en    = 1'b1;
    update_inval = inval;
    update_pc    = pc;
    update_bta   = tgt;
    update_type  = t;
    tick();
    update_en    = 1'b0;
    update_inval = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp_hit,
                      input int exp_way, input logic [31:0] exp_bta, input logic [1:0] exp_t);
    lookup_pc = pc;
    @(negedge clk);
    check({name, ".hit"}, 32'(hit), 32'(exp_hit));
    if (exp_hit) begin
      check({name, ".way"},  32'(hit_way), 32'(exp_way));
      check({name, ".bta"},  bta, exp_bta);
      check({name, ".type"}, 32'(br_type), 32'(exp_t));
    end
    tick();
  endtask

  task automatic count_flush(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      if (n == 5) check({name, ".bta_passthru"}, bta, lookup_pc);
      n++;
    end
    update_en = 1'b0;
    check({name, ".len"}, 32'(n), 32'd64);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    lookup_pc = 32'h400;
    count_flush("reset_flush");

    // Same-cycle lookup does not see the write; next cycle it hits way 0.
    lookup_pc   = 32'h1000;
    update_en   = 1'b1;
    update_pc   = 32'h1000;
    update_bta  = 32'h2000;
    update_type = 2'b01;
    @(negedge clk);
    check("same_cycle.hit", 32'(hit), 32'd0);
    tick();
    update_en = 1'b0;
    look("a_first", 32'h1000, 1'b1, 0, 32'h2000, 2'b01);

    // Three aliases in set 0: C evicts A.
    do_update(32'h1100, 32'h2100, 2'b10, 1'b0);
    do_update(32'h1200, 32'h2200, 2'b11, 1'b0);
    look("alias_a", 32'h1000, 1'b0, 0, 32'h0, 2'b00);
    look("alias_b", 32'h1100, 1'b1, 1, 32'h2100, 2'b10);
    look("alias_c", 32'h1200, 1'b1, 0, 32'h2200, 2'b11);

    // Set 1: touching A2 makes B2 the LRU victim for C2.
    do_update(32'h2004, 32'h3004, 2'b00, 1'b0);
    do_update(32'h2104, 32'h3104, 2'b01, 1'b0);
    look("lru_a", 32'h2004, 1'b1, 0, 32'h3004, 2'b00);
    do_update(32'h2204, 32'h3204, 2'b11, 1'b0);
    look("lru_b", 32'h2104, 1'b0, 0, 32'h0, 2'b00);
    look("lru_c", 32'h2204, 1'b1, 1, 32'h3204, 2'b11);
    look("lru_a2", 32'h2004, 1'b1, 0, 32'h3004, 2'b00);

    // Set 2: invalidate hit, then invalidate miss leaves everything alone.
    do_update(32'h3008, 32'h4008, 2'b01, 1'b0);
    do_update(32'h3008, 32'h0, 2'b00, 1'b1);
    look("inval_a", 32'h3008, 1'b0, 0, 32'h0, 2'b00);
    do_update(32'h3008, 32'h0, 2'b00, 1'b1);
    look("inval_again", 32'h3008, 1'b0, 0, 32'h0, 2'b00);
    do_update(32'h3108, 32'h4108, 2'b10, 1'b0);
    do_update(32'h3208, 32'h4208, 2'b11, 1'b0);
    do_update(32'h3308, 32'h4308, 2'b01, 1'b0);
    look("refill_b", 32'h3108, 1'b0, 0, 32'h0, 2'b00);
    look("refill_c", 32'h3208, 1'b1, 1, 32'h4208, 2'b11);
    look("refill_d", 32'h3308, 1'b1, 0, 32'h4308, 2'b01);

    // Flush request, ignored re-request, then reset at cycle 10 restarts it.
    lookup_pc = 32'h2004;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (4) tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    do_update(32'h5010, 32'h6010, 2'b01, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #2 reset = 1'b0;
    update_en   = 1'b1;
    update_pc   = 32'h6014;
    update_bta  = 32'h7014;
    update_type = 2'b10;
    count_flush("reflush");
    look("post_a2", 32'h2004, 1'b0, 0, 32'h0, 2'b00);
    look("post_c",  32'h1200, 1'b0, 0, 32'h0, 2'b00);
    look("post_d",  32'h3308, 1'b0, 0, 32'h0, 2'b00);
    look("post_e",  32'h5010, 1'b0, 0, 32'h0, 2'b00);
    look("post_f",  32'h6014, 1'b0, 0, 32'h0, 2'b00);
    do_update(32'h1000, 32'h2abc, 2'b10, 1'b0);
    look("recover", 32'h1000, 1'b1, 0, 32'h2abc, 2'b10);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer for the fetch stage.
- Lookup is combinational from the fetch PC and returns hit, way, branch target address (BTA) and branch type.
- Updates from branch resolution allocate a way or overwrite one in place, with true-LRU replacement per set.
- A sequential flush engine clears the array after reset and on request, one set per cycle.

Parameters:
SETS, 64, number of sets; power of two, 2..1024; IDX_W = log2(SETS)
WAYS, 2, associativity; power of two, 1..8; AGE_W = max(1, log2(WAYS))
TAG_W, 10, stored tag width; 4..16

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
lookup_pc  input  32  fetch PC to look up
hit  output  1  lookup hit in some valid way
hit_way  output  AGE_W  index of the hitting way; 0 on miss
bta  output  32  stored target on hit; lookup_pc on miss
type  output  2  stored type on hit; 2'b00 on miss (00 direct, 01 call, 10 return, 11 indirect)
update_en  input  1  write/allocate request
update_inval  input  1  with update_en: invalidate a matching entry instead of writing
update_pc  input  32  branch PC being updated
update_bta  input  32  resolved target
update_type  input  2  resolved branch type
flush_req  input  1  start a full invalidate
flush_busy  output  1  flush in progress

Behaviour:
- Index is pc[IDX_W+1:2].
- Tag is pc[31:IDX_W+2], zero-extended to a multiple of TAG_W and XOR-folded in TAG_W-bit chunks.
- Each entry holds valid, tag[TAG_W], bta[32] and type[2]. Each set holds one AGE_W-bit age per way; age 0 is MRU and WAYS-1 is LRU.
- Lookup is combinational and reads pre-edge state, with no bypass of a same-cycle update.
- If several ways match, which cannot happen in legal operation, the lowest-numbered way wins.
- LRU touch of way w: age[w] becomes 0; every way whose age is less than the old age[w] increments; all other ages are unchanged.
- Lookup hit while flush_busy=0: touch the hit way at the clock edge.
- Update write (update_en=1, update_inval=0, flush_busy=0):
  - If the tag matches a valid way in the set, overwrite that way's bta and type in place.
  - Otherwise allocate the lowest-index invalid way. If no way is invalid, allocate the way with age WAYS-1.
  - Write valid=1, tag, bta and type. Touch the written way.
- Update invalidate (update_en=1, update_inval=1): if the tag matches a valid way, clear its valid bit with no LRU change; on a miss, do nothing.
- Simultaneous lookup hit and update to the same set: only the update's effect on ages is applied. Entry writes always occur.
- Flush FSM has two states, IDLE and FLUSH, with a counter fidx[IDX_W].
  - Asserting reset forces FLUSH with fidx=0 immediately. This covers reset asserted mid-flush, which restarts the flush from set 0.
  - In IDLE, flush_req=1 moves the FSM to FLUSH with fidx=0 on the next edge.
  - In FLUSH, each cycle clears every valid bit in set fidx, sets age[w]=w for each way w, and increments fidx. When fidx=SETS-1, the FSM returns to IDLE.
  - flush_busy = (state==FLUSH). A flush takes exactly SETS cycles.
  - flush_req while FLUSH is ignored.
- While flush_busy=1: hit=0, hit_way=0, bta=lookup_pc, type=2'b00. Updates are dropped, not queued, and lookups touch nothing.
- Reset values: state FLUSH, fidx 0, flush_busy 1, hit 0, type 00. Array contents are undefined until the flush completes.
- WAYS=1: AGE_W is 1 but ages are unused, and the victim is always way 0.

Test Plan:
- Deassert reset, then hold lookup_pc=0x400 -> flush_busy=1 for exactly 64 cycles, then 0; hit=0, bta=0x400, type=00 throughout.
- Update pc=0x1000, bta=0x2000, type=01, then look up 0x1000 next cycle -> hit=1, hit_way=0, bta=0x2000, type=01. Same-cycle lookup -> miss.
- Write three aliasing PCs A, B, C (same index, different tags, WAYS=2) -> C replaces A. A misses; B and C hit.
- Look up A (hit), then write C -> C replaces B, the LRU way, not A.
- Write A, then update_inval for A -> lookup A misses. Repeat update_inval for A -> no change, and ages are unchanged.
- Assert flush_req mid-run, then reassert reset at cycle 10 of the flush -> flush_busy stays high for a full 64 cycles after reset; all prior entries miss; updates during the flush are dropped.
